// File: rtl/count_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | count_ctrl_pkg: shared command and state encodings for count_seq_ctrl |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package count_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_START = 2'b01,
    OP_STOP  = 2'b10,
    OP_PAUSE = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/counter_en_clr.sv
// +----------------------------------------------------------------------+
// | counter_en_clr: up-counter with synchronous clear and count enable    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module counter_en_clr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/count_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | count_seq_ctrl: command-driven sequencer for a prescaled up-counter   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module count_seq_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_limit,
  input  logic                  cmd_autoreload,
  input  logic [PRESCALE_W-1:0] cmd_prescale,
  output logic [WIDTH-1:0]      cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  tc_pulse
);

  ctrl_state_e           r_state;
  ctrl_state_e           w_state_nxt;
  logic                  r_ready;
  logic                  r_tc_pulse;
  logic [WIDTH-1:0]      r_limit;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_autoreload;

  cmd_op_e               w_op;
  logic                  w_accept;
  logic                  w_restart;
  logic                  w_tick;
  logic                  w_terminal;
  logic [WIDTH-1:0]      w_cnt;
  logic [PRESCALE_W-1:0] w_presc;

  assign w_op      = cmd_op_e'(cmd_op);
  assign w_accept  = cmd_valid && r_ready;
  assign w_restart = w_accept && ((w_op == OP_START) || (w_op == OP_STOP));

  // Any accepted command owns the edge: the tick is discarded and presc holds.
  assign w_tick     = (r_state == S_RUN) && !w_accept && (w_presc == r_prescale);
  assign w_terminal = w_tick && (w_cnt == r_limit);

  counter_en_clr #(
    .WIDTH(WIDTH)
  ) u_count (
    .clk (clk),
    .rst (rst),
    .clr (w_restart || (w_terminal && r_autoreload)),
    .en  (w_tick && !w_terminal),
    .q   (w_cnt)
  );

  counter_en_clr #(
    .WIDTH(PRESCALE_W)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (w_restart || w_tick),
    .en  ((r_state == S_RUN) && !w_accept),
    .q   (w_presc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      unique case (w_op)
        OP_START: w_state_nxt = S_RUN;
        OP_STOP:  w_state_nxt = S_IDLE;
        OP_PAUSE: begin
          if (r_state == S_RUN) begin
            w_state_nxt = S_PAUSE;
          end else if (r_state == S_PAUSE) begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end else if (w_terminal && !r_autoreload) begin
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready      <= 1'b1;
      r_tc_pulse   <= 1'b0;
      r_limit      <= '0;
      r_prescale   <= '0;
      r_autoreload <= 1'b0;
    end else begin
      r_ready    <= !w_accept;
      r_tc_pulse <= w_terminal;
      if (w_accept && (w_op == OP_START)) begin
        r_limit      <= cmd_limit;
        r_prescale   <= cmd_prescale;
        r_autoreload <= cmd_autoreload;
      end
    end
  end

  assign cmd_ready = r_ready;
  assign cnt       = w_cnt;
  assign busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done      = (r_state == S_DONE);
  assign tc_pulse  = r_tc_pulse;

endmodule

`default_nettype wire

// File: tb/tb_count_seq_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_count_seq_ctrl: directed and random checks against a cycle model   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_count_seq_ctrl;

  localparam int W  = 3;
  localparam int PW = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [W-1:0]  cmd_limit = '0;
  logic          cmd_autoreload = 1'b0;
  logic [PW-1:0] cmd_prescale = '0;
  logic [W-1:0]  cnt;
  logic          busy;
  logic          done;
  logic          tc_pulse;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_mode, m_cnt, m_presc, m_lim, m_pre, m_ar, m_ready, m_tc;
  int tc_seen;

  always #5 clk = ~clk;

  count_seq_ctrl #(
    .WIDTH(W),
    .PRESCALE_W(PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_limit      (cmd_limit),
    .cmd_autoreload (cmd_autoreload),
    .cmd_prescale   (cmd_prescale),
    .cnt            (cnt),
    .busy           (busy),
    .done           (done),
    .tc_pulse       (tc_pulse)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int acc;
    acc  = (cmd_valid && m_ready != 0) ? 1 : 0;
    m_tc = 0;
    if (rst) begin
      m_mode = M_IDLE; m_cnt = 0; m_presc = 0;
      m_lim = 0; m_pre = 0; m_ar = 0; m_ready = 1;
      return;
    end
    m_ready = acc ? 0 : 1;
    if (acc != 0) begin
      case (int'(cmd_op))
        1: begin
          m_lim = int'(cmd_limit); m_pre = int'(cmd_prescale); m_ar = int'(cmd_autoreload);
          m_mode = M_RUN; m_cnt = 0; m_presc = 0;
        end
        2: begin m_mode = M_IDLE; m_cnt = 0; m_presc = 0; end
        3: begin
          if (m_mode == M_RUN) m_mode = M_PAUSE;
          else if (m_mode == M_PAUSE) m_mode = M_RUN;
        end
        default: ;
      endcase
    end else if (m_mode == M_RUN) begin
      if (m_presc == m_pre) begin
        m_presc = 0;
        if (m_cnt == m_lim) begin
          m_tc = 1;
          if (m_ar != 0) m_cnt = 0;
          else m_mode = M_DONE;
        end else begin
          m_cnt = (m_cnt + 1) % (1 << W);
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("cnt", int'(cnt), m_cnt);
    chk("busy", int'(busy), (m_mode == M_RUN || m_mode == M_PAUSE) ? 1 : 0);
    chk("done", int'(done), (m_mode == M_DONE) ? 1 : 0);
    chk("tc_pulse", int'(tc_pulse), m_tc);
    chk("cmd_ready", int'(cmd_ready), m_ready);
    if (tc_pulse) tc_seen++;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input int op, input int lim, input int ar, input int pre);
    if (m_ready == 0) idle(1);
    cmd_valid      = 1'b1;
    cmd_op         = 2'(op);
    cmd_limit      = W'(lim);
    cmd_autoreload = 1'(ar);
    cmd_prescale   = PW'(pre);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    m_mode = M_IDLE; m_cnt = 0; m_presc = 0; m_lim = 0; m_pre = 0;
    m_ar = 0; m_ready = 1; m_tc = 0; tc_seen = 0;

    #1;
    rst = 1'b1;
    step();
    step();
    chk("reset_ready", int'(cmd_ready), 1);
    chk("reset_cnt", int'(cnt), 0);
    rst = 1'b0;

    // One-shot, limit 3, no prescale
    issue(1, 3, 0, 0);
    idle(6);
    chk("oneshot_done", int'(done), 1);
    chk("oneshot_hold", int'(cnt), 3);
    chk("oneshot_busy", int'(busy), 0);

    // Auto-reload with prescale 1
    issue(1, 2, 1, 1);
    tc_seen = 0;
    idle(18);
    chk("reload_tc_count", tc_seen, 3);
    chk("reload_not_done", int'(done), 0);

    // Pause and resume mid-count
    issue(1, 7, 0, 0);
    idle(1);
    chk("pause_pre_cnt", int'(cnt), 1);
    issue(3, 0, 0, 0);
    idle(5);
    chk("pause_hold_cnt", int'(cnt), 1);
    chk("pause_busy", int'(busy), 1);
    issue(3, 0, 0, 0);
    idle(1);
    chk("resume_cnt", int'(cnt), 2);

    // STOP on the same edge as the terminal tick
    issue(1, 1, 0, 0);
    idle(1);
    tc_seen = 0;
    issue(2, 0, 0, 0);
    idle(3);
    chk("stop_tc_never", tc_seen, 0);
    chk("stop_cnt", int'(cnt), 0);
    chk("stop_done", int'(done), 0);

    // cmd_valid held high across START then STOP
    idle(1);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_limit = 3'd5; cmd_prescale = '0; cmd_autoreload = 1'b0;
    step();
    chk("hold_ready_after_start", int'(cmd_ready), 0);
    cmd_op = 2'd2;
    step();
    chk("hold_ready_back", int'(cmd_ready), 1);
    step();
    chk("hold_stop_taken", int'(busy), 0);
    cmd_valid = 1'b0;

    // Reset while running at cnt=5
    issue(1, 7, 0, 0);
    idle(5);
    chk("pre_rst_cnt", int'(cnt), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_run_cnt", int'(cnt), 0);
    chk("rst_run_busy", int'(busy), 0);
    chk("rst_run_ready", int'(cmd_ready), 1);

    // limit 0, prescale 3, auto-reload
    issue(1, 0, 1, 3);
    tc_seen = 0;
    idle(16);
    chk("lim0_tc_count", tc_seen, 4);
    chk("lim0_cnt", int'(cnt), 0);

    // Full-range limit without overflow
    issue(1, (1 << W) - 1, 0, 0);
    idle(10);
    chk("maxlim_done", int'(done), 1);
    chk("maxlim_cnt", int'(cnt), (1 << W) - 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 99) == 0);
      cmd_valid      = ($urandom_range(0, 9) < 3);
      cmd_op         = 2'($urandom_range(0, 3));
      cmd_limit      = W'($urandom_range(0, (1 << W) - 1));
      cmd_autoreload = 1'($urandom_range(0, 1));
      cmd_prescale   = PW'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
